// File: rtl/fwd_bypass_unit.sv
// Operand bypass network: live E result plus a DEPTH-entry write history,
// youngest-match forwarding for rs1/rs2, load-use stall detection and load fill.
module fwd_bypass_unit #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int CNTW  = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      rs1_D,
    input  logic [4:0]      rs2_D,
    input  logic [XLEN-1:0] rdata1,
    input  logic [XLEN-1:0] rdata2,
    input  logic            wr_en_E,
    input  logic [4:0]      rd_E,
    input  logic [XLEN-1:0] wdata_E,
    input  logic            is_load_E,
    input  logic            load_valid,
    input  logic [XLEN-1:0] load_data,
    input  logic            flush,
    output logic [XLEN-1:0] forwarded_A,
    output logic [XLEN-1:0] forwarded_B,
    output logic            stall,
    output logic [CNTW-1:0] stall_cnt,
    output logic            lost_load_err
);

    typedef struct packed {
        logic            valid;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
        logic            pending;
    } hist_t;

    hist_t            r_hist [DEPTH];
    logic             r_lost_load_err;
    logic [CNTW-1:0]  r_stall_cnt;

    logic [4:0]       w_rs     [2];
    logic [XLEN-1:0]  w_rdata  [2];
    logic [XLEN-1:0]  w_fwd    [2];
    logic [1:0]       w_hazard;
    logic             w_found;
    logic [DEPTH-1:0] w_fill_sel;
    logic             w_fill_found;
    logic             w_new_valid;
    logic             w_stall;

    assign w_rs[0]     = rs1_D;
    assign w_rs[1]     = rs2_D;
    assign w_rdata[0]  = rdata1;
    assign w_rdata[1]  = rdata2;
    assign w_new_valid = wr_en_E && (rd_E != 5'd0);

    // Youngest match wins: live E result first, then entry 0 .. DEPTH-1.
    // A pending winner is a hazard and leaves the operand at rdata.
    always_comb begin
        w_found = 1'b0;
        for (int op = 0; op < 2; op++) begin
            w_fwd[op]    = w_rdata[op];
            w_hazard[op] = 1'b0;
            w_found      = 1'b0;
            if (w_rs[op] != 5'd0) begin
                if (wr_en_E && (rd_E == w_rs[op])) begin
                    w_found = 1'b1;
                    if (is_load_E) w_hazard[op] = 1'b1;
                    else           w_fwd[op]    = wdata_E;
                end
                for (int i = 0; i < DEPTH; i++) begin
                    if (!w_found && r_hist[i].valid && (r_hist[i].rd == w_rs[op])) begin
                        w_found = 1'b1;
                        if (r_hist[i].pending) w_hazard[op] = 1'b1;
                        else                   w_fwd[op]    = r_hist[i].data;
                    end
                end
            end
        end
    end

    // Returning load data belongs to the oldest outstanding load in the history.
    always_comb begin
        w_fill_sel   = '0;
        w_fill_found = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!w_fill_found && r_hist[i].valid && r_hist[i].pending) begin
                w_fill_sel[i] = load_valid;
                w_fill_found  = 1'b1;
            end
        end
    end

    assign w_stall     = !rst && (|w_hazard);
    assign stall       = w_stall;
    assign forwarded_A = rst ? rdata1 : w_fwd[0];
    assign forwarded_B = rst ? rdata2 : w_fwd[1];

    // NOTE: data/rd are reset with the flags; at this depth it is cheap and keeps X out of the forward muxes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_hist[i] <= '0;
            r_lost_load_err <= 1'b0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_hist[i].valid   <= 1'b0;
                r_hist[i].pending <= 1'b0;
            end
        end else begin
            r_hist[0] <= '{valid: w_new_valid, rd: rd_E, data: wdata_E,
                           pending: w_new_valid && is_load_E};
            // A fill lands in the entry's post-shift slot.
            for (int i = 1; i < DEPTH; i++) begin
                r_hist[i] <= r_hist[i-1];
                if (w_fill_sel[i-1]) begin
                    r_hist[i].data    <= load_data;
                    r_hist[i].pending <= 1'b0;
                end
            end
            if (r_hist[DEPTH-1].valid && r_hist[DEPTH-1].pending && !w_fill_sel[DEPTH-1])
                r_lost_load_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_stall_cnt <= '0;
        else if (w_stall && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + CNTW'(1);
    end

    assign stall_cnt     = r_stall_cnt;
    assign lost_load_err = r_lost_load_err;

endmodule

// File: tb/tb_fwd_bypass_unit.sv
// Self-checking bench for fwd_bypass_unit: queue-based reference model compared
// every cycle, directed scenarios with literal expectations, random traffic, saturation.
module tb_fwd_bypass_unit;

    localparam int XLEN = 32;
    localparam int DEPTH = 2;
    localparam int CNTW = 16;
    localparam longint CNT_MAX = (64'd1 << CNTW) - 1;

    logic            clk;
    logic            rst;
    logic [4:0]      rs1_D, rs2_D, rd_E;
    logic [XLEN-1:0] rdata1, rdata2, wdata_E, load_data;
    logic            wr_en_E, is_load_E, load_valid, flush;
    logic [XLEN-1:0] forwarded_A, forwarded_B;
    logic            stall;
    logic [CNTW-1:0] stall_cnt;
    logic            lost_load_err;

    int n_tests = 0;
    int n_fail  = 0;

    fwd_bypass_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst),
        .rs1_D(rs1_D), .rs2_D(rs2_D), .rdata1(rdata1), .rdata2(rdata2),
        .wr_en_E(wr_en_E), .rd_E(rd_E), .wdata_E(wdata_E), .is_load_E(is_load_E),
        .load_valid(load_valid), .load_data(load_data), .flush(flush),
        .forwarded_A(forwarded_A), .forwarded_B(forwarded_B),
        .stall(stall), .stall_cnt(stall_cnt), .lost_load_err(lost_load_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: history as a queue, index 0 youngest.
    typedef struct {
        bit            valid;
        bit [4:0]      rd;
        bit [XLEN-1:0] data;
        bit            pending;
    } ent_t;

    ent_t   hist[$];
    longint m_cnt;
    bit     m_err;

    function automatic void m_reset();
        ent_t z;
        z = '{valid: 1'b0, rd: 5'd0, data: '0, pending: 1'b0};
        hist.delete();
        repeat (DEPTH) hist.push_back(z);
        m_cnt = 0;
        m_err = 1'b0;
    endfunction

    function automatic void resolve(input logic [4:0] rs, input logic [XLEN-1:0] rdata,
                                    output logic [XLEN-1:0] v, output bit haz);
        ent_t cand[$];
        v   = rdata;
        haz = 1'b0;
        cand = hist;
        if (wr_en_E)
            cand.push_front('{valid: 1'b1, rd: rd_E, data: wdata_E, pending: is_load_E});
        if (rs == 5'd0) return;
        foreach (cand[i]) begin
            if (cand[i].valid && cand[i].rd == rs) begin
                if (cand[i].pending) haz = 1'b1;
                else                 v   = cand[i].data;
                return;
            end
        end
    endfunction

    function automatic void m_step(input bit es);
        int   f;
        ent_t old;
        bit   nv;
        if (es) m_cnt = (m_cnt == CNT_MAX) ? CNT_MAX : m_cnt + 1;
        if (flush) begin
            foreach (hist[i]) begin
                hist[i].valid   = 1'b0;
                hist[i].pending = 1'b0;
            end
            return;
        end
        f = -1;
        foreach (hist[i]) if (hist[i].valid && hist[i].pending) f = i;
        if (load_valid && f >= 0) begin
            hist[f].data    = load_data;
            hist[f].pending = 1'b0;
        end
        old = hist.pop_back();
        if (old.valid && old.pending) m_err = 1'b1;
        nv = wr_en_E && (rd_E != 5'd0);
        hist.push_front('{valid: nv, rd: rd_E, data: wdata_E, pending: nv && is_load_E});
    endfunction

    initial m_reset();

    // Compare process: outputs mid-cycle vs model, then advance the model.
    always @(negedge clk) begin : cmp
        logic [XLEN-1:0] ea, eb;
        bit              ha, hb;
        if (rst) begin
            check("rst_fwd_a", forwarded_A, rdata1);
            check("rst_fwd_b", forwarded_B, rdata2);
            check("rst_stall", stall, 1'b0);
            check("rst_cnt", stall_cnt, 0);
            check("rst_err", lost_load_err, 1'b0);
            m_reset();
        end else begin
            resolve(rs1_D, rdata1, ea, ha);
            resolve(rs2_D, rdata2, eb, hb);
            check("stall", stall, ha | hb);
            if (!ha) check("fwd_a", forwarded_A, ea);
            if (!hb) check("fwd_b", forwarded_B, eb);
            check("stall_cnt", stall_cnt, m_cnt);
            check("lost_load_err", lost_load_err, m_err);
            m_step(ha | hb);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
        wr_en_E    = 1'b0;
        is_load_E  = 1'b0;
        load_valid = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        next_cycle();
        rst = 1'b1;
        sample();
        check("pulse_rst_err", lost_load_err, 1'b0);
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        rs1_D = 5'd0; rs2_D = 5'd0; rd_E = 5'd0;
        rdata1 = '0; rdata2 = '0; wdata_E = '0; load_data = '0;
        wr_en_E = 1'b0; is_load_E = 1'b0; load_valid = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        next_cycle();
        rst = 1'b0;

        // Empty history reads the register file.
        next_cycle();
        rs1_D = 5'd5; rdata1 = 32'h11; rs2_D = 5'd0; rdata2 = 32'h22;
        sample();
        check("empty_a", forwarded_A, 32'h11);
        check("empty_stall", stall, 1'b0);
        check("empty_cnt", stall_cnt, 0);

        // Live E write forwards the same cycle, then from history, then expires.
        next_cycle();
        rs2_D = 5'd5; wr_en_E = 1'b1; rd_E = 5'd5; wdata_E = 32'hAA;
        sample();
        check("live_a", forwarded_A, 32'hAA);
        check("live_b", forwarded_B, 32'hAA);
        next_cycle();
        sample();
        check("hist0_a", forwarded_A, 32'hAA);
        repeat (DEPTH) next_cycle();
        sample();
        check("expired_a", forwarded_A, 32'h11);

        // Load-use: stall while pending, fill, then forward the loaded value.
        next_cycle();
        rs1_D = 5'd0; rs2_D = 5'd0; wr_en_E = 1'b1; is_load_E = 1'b1; rd_E = 5'd7; wdata_E = 32'hDEAD;
        sample();
        check("ld_issue_stall", stall, 1'b0);
        next_cycle();
        rs2_D = 5'd7; load_valid = 1'b1; load_data = 32'h1234;
        sample();
        check("ld_pending_stall", stall, 1'b1);
        next_cycle();
        sample();
        check("ld_fill_b", forwarded_B, 32'h1234);
        check("ld_fill_stall", stall, 1'b0);
        check("ld_fill_cnt", stall_cnt, 1);

        // Youngest of several x3 writers wins; younger pending beats older ready.
        rs2_D = 5'd0;
        next_cycle();
        rs1_D = 5'd3; wr_en_E = 1'b1; rd_E = 5'd3; wdata_E = 32'h1;
        next_cycle();
        wr_en_E = 1'b1; rd_E = 5'd3; wdata_E = 32'h2;
        next_cycle();
        wr_en_E = 1'b1; rd_E = 5'd3; wdata_E = 32'h3;
        sample();
        check("prio_live", forwarded_A, 32'h3);
        wr_en_E = 1'b0;
        #1;
        check("prio_entry0", forwarded_A, 32'h2);
        wr_en_E = 1'b1;
        next_cycle();
        wr_en_E = 1'b1; is_load_E = 1'b1; rd_E = 5'd3;
        next_cycle();
        sample();
        check("prio_pending_stall", stall, 1'b1);

        // x0 is never forwarded.
        next_cycle();
        rs1_D = 5'd0; rdata1 = 32'h0; rs2_D = 5'd0; rdata2 = 32'h5;
        wr_en_E = 1'b1; rd_E = 5'd0; wdata_E = 32'hFF;
        sample();
        check("x0_a", forwarded_A, 32'h0);
        check("x0_b", forwarded_B, 32'h5);
        check("x0_stall", stall, 1'b0);

        // Unfilled load shifting out raises the sticky error.
        do_reset();
        wr_en_E = 1'b1; is_load_E = 1'b1; rd_E = 5'd9;
        sample();
        check("lost_f0", lost_load_err, 1'b0);
        next_cycle();
        next_cycle();
        sample();
        check("lost_f2", lost_load_err, 1'b0);
        next_cycle();
        sample();
        check("lost_f3", lost_load_err, 1'b1);

        // Flush empties the history; the error stays.
        next_cycle();
        wr_en_E = 1'b1; is_load_E = 1'b1; rd_E = 5'd4;
        next_cycle();
        rs1_D = 5'd4; rdata1 = 32'h44; flush = 1'b1;
        sample();
        check("flush_stall_before", stall, 1'b1);
        next_cycle();
        sample();
        check("flush_stall_after", stall, 1'b0);
        check("flush_a", forwarded_A, 32'h44);
        check("flush_err_kept", lost_load_err, 1'b1);
        do_reset();
        sample();
        check("err_cleared", lost_load_err, 1'b0);

        // Random traffic over a small register range to force collisions.
        for (int k = 0; k < 3000; k++) begin
            next_cycle();
            rs1_D      = 5'($urandom_range(0, 7));
            rs2_D      = 5'($urandom_range(0, 7));
            rdata1     = $urandom;
            rdata2     = $urandom;
            wr_en_E    = ($urandom_range(0, 9) < 7);
            rd_E       = 5'($urandom_range(0, 7));
            wdata_E    = $urandom;
            is_load_E  = ($urandom_range(0, 9) < 3);
            load_valid = ($urandom_range(0, 9) < 3);
            load_data  = $urandom;
            flush      = ($urandom_range(0, 19) == 0);
        end

        // Saturate the stall counter with a permanent live load-use hazard.
        do_reset();
        rs2_D = 5'd0;
        for (int k = 0; k < 65540; k++) begin
            if (k != 0) next_cycle();
            rs1_D = 5'd1; wr_en_E = 1'b1; is_load_E = 1'b1; rd_E = 5'd1;
        end
        next_cycle();
        rs1_D = 5'd0;
        sample();
        check("cnt_saturated", stall_cnt, 16'hFFFF);

        next_cycle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
